// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: one buffered entry pairs an instruction with its PC.
package fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch back end: pairs memory read data with its PC, buffers pairs for decode,
// drives next-PC/stall to fetch and flushes everything on a redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  output logic        stall,
  output logic [31:0] pc_update,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_pc,
  output logic [31:0] deq_instr
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          req_valid_q;
  logic [31:0]   req_pc_q;
  logic          rst_prev_q;
  logic          enq;
  logic          fire;
  logic [PW+1:0] occupancy;

  // The in-flight request already owns a slot, so stalling on count+req_valid
  // guarantees its data always has somewhere to land.
  assign occupancy = {1'b0, count_q} + {{(PW+1){1'b0}}, req_valid_q};
  assign stall     = occupancy >= (PW+2)'(DEPTH);

  assign enq       = req_valid_q & ~redirect;
  assign deq_valid = (count_q != '0) & ~redirect;
  assign fire      = deq_valid & deq_ready;
  assign pc_update = redirect ? redirect_target : fetch_pc + 32'(INSTR_BYTES);
  assign deq_pc    = mem_q[head_q].pc;
  assign deq_instr = mem_q[head_q].instr;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)  tail_d = tail_q + PW'(1);
      if (fire) head_d = head_q + PW'(1);
      case ({enq, fire})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      req_valid_q <= ~stall & ~redirect;
      req_pc_q    <= fetch_pc;
    end
    rst_prev_q <= reset;
  end

  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem_q[tail_q] <= '{pc: req_pc_q, instr: fetch_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(enq && count_q == (PW+1)'(DEPTH)));
      assert (!(fire && count_q == '0));
      if (rst_prev_q) assert (fetch_pc == RESET_PC);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small fetch-stage/imem model around it.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] XMASK    = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr = '0;
  logic        stall;
  logic [31:0] pc_update;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_pc;
  logic [31:0] deq_instr;

  logic [31:0] pc_q = RESET_PC;
  logic [31:0] force_pc = '0;
  logic        force_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DEPTH(8), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .stall(stall), .pc_update(pc_update), .redirect(redirect),
    .redirect_target(redirect_target), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr)
  );

  always #5 clk = ~clk;

  // Fetch stage and one-cycle-latency instruction memory.
  assign fetch_pc = force_en ? force_pc : pc_q;
  always @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else if (redirect || !stall) pc_q <= pc_update;
    fetch_instr <= fetch_pc ^ XMASK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after release, inputs settled.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
  endtask

  int unsigned n_fire;
  logic [31:0] exp_pc;

  initial begin
    // Reset values and basic streaming latency
    deq_ready = 1'b1;
    reset = 1'b1;
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    do_reset();
    check("t1_c0_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("t1_c1_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("t1_c2_valid", {31'd0, deq_valid}, 32'd1);
    check("t1_c2_pc", deq_pc, 32'h8000_0000);
    check("t1_c2_instr", deq_instr, 32'h8000_0000 ^ XMASK);
    tick();
    check("t1_c3_pc", deq_pc, 32'h8000_0004);
    tick();
    check("t1_c4_pc", deq_pc, 32'h8000_0008);
    for (int i = 0; i < 6; i++) begin
      check("t1_stall", {31'd0, stall}, 32'd0);
      check("t1_stream_pc", deq_pc, 32'h8000_0008 + 32'(4 * i));
      tick();
    end

    // Fill to capacity with the consumer blocked
    deq_ready = 1'b0;
    do_reset();
    repeat (7) tick();
    check("t2_c7_stall", {31'd0, stall}, 32'd0);
    tick();
    check("t2_c8_stall", {31'd0, stall}, 32'd1);
    tick();
    check("t2_c9_stall", {31'd0, stall}, 32'd1);
    check("t2_c9_fetch_pc_held", fetch_pc, 32'h8000_0020);
    tick();
    check("t2_c10_stall", {31'd0, stall}, 32'd1);
    check("t2_c10_head", deq_pc, 32'h8000_0000);
    deq_ready = 1'b1;
    #1;
    tick();
    check("t2_c11_stall", {31'd0, stall}, 32'd0);
    for (int i = 1; i < 10; i++) begin
      check("t2_drain_valid", {31'd0, deq_valid}, 32'd1);
      check("t2_drain_pc", deq_pc, 32'h8000_0000 + 32'(4 * i));
      tick();
    end

    // Redirect with 5 buffered + 1 in flight
    deq_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    check("t3_pre_valid", {31'd0, deq_valid}, 32'd1);
    redirect = 1'b1;
    redirect_target = 32'h8000_0100;
    #1;
    check("t3_r_valid", {31'd0, deq_valid}, 32'd0);
    check("t3_r_pc_update", pc_update, 32'h8000_0100);
    tick();
    redirect = 1'b0;
    deq_ready = 1'b1;
    #1;
    check("t3_r1_valid", {31'd0, deq_valid}, 32'd0);
    check("t3_r1_stall", {31'd0, stall}, 32'd0);
    tick();
    check("t3_r2_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("t3_r3_valid", {31'd0, deq_valid}, 32'd1);
    check("t3_r3_pc", deq_pc, 32'h8000_0100);
    tick();
    check("t3_r4_pc", deq_pc, 32'h8000_0104);

    // Redirect while full
    deq_ready = 1'b0;
    do_reset();
    repeat (9) tick();
    check("t4_full_stall", {31'd0, stall}, 32'd1);
    redirect = 1'b1;
    redirect_target = 32'h8000_0200;
    #1;
    check("t4_r_pc_update", pc_update, 32'h8000_0200);
    check("t4_r_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    deq_ready = 1'b1;
    #1;
    check("t4_r1_stall", {31'd0, stall}, 32'd0);
    check("t4_r1_valid", {31'd0, deq_valid}, 32'd0);
    check("t4_r1_fetch_pc", fetch_pc, 32'h8000_0200);
    tick();
    check("t4_r2_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("t4_r3_valid", {31'd0, deq_valid}, 32'd1);
    check("t4_r3_pc", deq_pc, 32'h8000_0200);

    // PC increment wrap and redirect select (held in reset)
    reset = 1'b1;
    tick();
    force_en = 1'b1;
    force_pc = 32'hFFFF_FFFC;
    #1;
    check("t5_wrap", pc_update, 32'h0000_0000);
    force_pc = 32'h1234_5678;
    #1;
    check("t5_inc", pc_update, 32'h1234_567C);
    redirect = 1'b1;
    redirect_target = 32'h8000_0300;
    #1;
    check("t5_redirect_sel", pc_update, 32'h8000_0300);
    redirect = 1'b0;
    force_en = 1'b0;
    #1;

    // Reset mid-operation with 4 entries buffered
    deq_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    check("t6_pre_valid", {31'd0, deq_valid}, 32'd1);
    reset = 1'b1;
    tick();
    tick();
    check("t6_rst_valid", {31'd0, deq_valid}, 32'd0);
    check("t6_rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    #1;
    check("t6_c0_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("t6_c1_valid", {31'd0, deq_valid}, 32'd0);
    tick();
    check("t6_c2_valid", {31'd0, deq_valid}, 32'd1);
    check("t6_c2_pc", deq_pc, 32'h8000_0000);

    // Random consumer soak against an in-order PC scoreboard
    exp_pc = 32'h8000_0000;
    n_fire = 0;
    for (int i = 0; i < 400; i++) begin
      deq_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (deq_valid && deq_ready) begin
        check("soak_pc", deq_pc, exp_pc);
        check("soak_instr", deq_instr, exp_pc ^ XMASK);
        exp_pc = exp_pc + 32'd4;
        n_fire++;
      end
      tick();
    end
    check("soak_progress", {31'd0, n_fire > 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
